// File: rtl/bch_correct.sv
// Sequential 1/2-bit error locator and corrector for a systematic BCH/Hamming codeword.
// Columns are x^k mod pGenPoly, so they match a cyclic-remainder syndrome calculator.
module bch_correct #(
  parameter int unsigned            pDataWidth   = 16,
  parameter int unsigned            pParityWidth = 11,
  parameter int unsigned            pCodeWidth   = 27,
  parameter int unsigned            pMaxErrors   = 2,
  parameter logic [pParityWidth:0]  pGenPoly     = 12'h9BB
) (
  input  logic                    clk,
  input  logic                    rst_x,
  input  logic                    i_enable,
  input  logic                    i_valid,
  output logic                    o_in_ready,
  input  logic [pCodeWidth-1:0]   i_code,
  input  logic [pParityWidth-1:0] i_syndrome,
  output logic                    o_valid,
  input  logic                    i_out_ready,
  output logic [pDataWidth-1:0]   o_data,
  output logic [1:0]              o_err_cnt,
  output logic                    o_uncorrectable
);

  localparam int unsigned idx_w    = $clog2(pCodeWidth);
  localparam int unsigned num_cols = 1 << idx_w;

  typedef enum logic [1:0] {IDLE, SYN, SEARCH, DONE} state_t;

  state_t                  state;
  logic [pCodeWidth-1:0]   code_q;
  logic [pParityWidth-1:0] syn_q;
  logic [idx_w-1:0]        idx;

  // Parity-check column k = x^k mod g(x); bits k < parity width come out one-hot
  function automatic logic [pParityWidth-1:0] col_of(input int k);
    logic [pParityWidth-1:0] r;
    r = pParityWidth'(1);
    for (int n = 0; n < k; n++) begin
      if (r[pParityWidth-1]) r = (r << 1) ^ pGenPoly[pParityWidth-1:0];
      else                   r = r << 1;
    end
    return r;
  endfunction

  logic [pParityWidth-1:0] col [num_cols];

  for (genvar k = 0; k < num_cols; k++) begin : g_col
    if (k < pCodeWidth) begin : g_used
      assign col[k] = col_of(k);
    end else begin : g_pad
      assign col[k] = '0;
    end
  end

  logic [pParityWidth-1:0] col_i;
  logic [pParityWidth-1:0] residual;
  logic                    single_hit;
  logic                    double_hit;
  logic [idx_w-1:0]        double_k;
  logic [pCodeWidth-1:0]   flip_i;
  logic [pCodeWidth-1:0]   flip_k;

  // Single-hit test on the current index, plus lowest partner k > idx for a double hit
  always_comb begin
    col_i      = col[idx];
    residual   = syn_q ^ col_i;
    single_hit = (syn_q == col_i);
    double_hit = 1'b0;
    double_k   = '0;
    if (pMaxErrors == 2) begin
      for (int k = pCodeWidth - 1; k >= 0; k--) begin
        if ((idx_w'(k) > idx) && (col[k] == residual)) begin
          double_hit = 1'b1;
          double_k   = idx_w'(k);
        end
      end
    end
    flip_i = pCodeWidth'(1) << idx;
    flip_k = pCodeWidth'(1) << double_k;
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state           <= IDLE;
      code_q          <= '0;
      syn_q           <= '0;
      idx             <= '0;
      o_in_ready      <= 1'b0;
      o_valid         <= 1'b0;
      o_data          <= '0;
      o_err_cnt       <= 2'd0;
      o_uncorrectable <= 1'b0;
    end else if (!i_enable) begin
      // Abort: drop any in-flight word, including one whose syndrome would read as zero
      state           <= IDLE;
      o_in_ready      <= 1'b1;
      o_valid         <= 1'b0;
      o_data          <= '0;
      o_err_cnt       <= 2'd0;
      o_uncorrectable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_in_ready <= 1'b1;
          if (i_valid && o_in_ready) begin
            code_q     <= i_code;
            o_in_ready <= 1'b0;
            state      <= SYN;
          end
        end
        SYN: begin
          syn_q <= i_syndrome;
          idx   <= '0;
          if (i_syndrome == '0) begin
            o_valid         <= 1'b1;
            o_data          <= pDataWidth'(code_q >> pParityWidth);
            o_err_cnt       <= 2'd0;
            o_uncorrectable <= 1'b0;
            state           <= DONE;
          end else begin
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (single_hit) begin
            o_valid         <= 1'b1;
            o_data          <= pDataWidth'((code_q ^ flip_i) >> pParityWidth);
            o_err_cnt       <= 2'd1;
            o_uncorrectable <= 1'b0;
            state           <= DONE;
          end else if (double_hit) begin
            o_valid         <= 1'b1;
            o_data          <= pDataWidth'((code_q ^ flip_i ^ flip_k) >> pParityWidth);
            o_err_cnt       <= 2'd2;
            o_uncorrectable <= 1'b0;
            state           <= DONE;
          end else if (idx == idx_w'(pCodeWidth - 1)) begin
            o_valid         <= 1'b1;
            o_data          <= pDataWidth'(code_q >> pParityWidth);
            o_err_cnt       <= 2'd0;
            o_uncorrectable <= 1'b1;
            state           <= DONE;
          end else begin
            idx <= idx + idx_w'(1);
          end
        end
        DONE: begin
          if (i_out_ready) begin
            o_valid    <= 1'b0;
            o_in_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_correct.sv
// Bench for bch_correct: polynomial-remainder reference model, per-cycle output compare,
// directed latency/abort/reset cases and an exhaustive 1/2-bit error sweep.
module tb_bch_correct;

  localparam logic [63:0] G_A = 64'h9BB;
  localparam logic [63:0] G_H = 64'h6F;

  logic        clk = 1'b0;
  logic        rst_x, i_enable, valid_a, valid_h, out_ready;
  logic [26:0] code;
  logic [10:0] syn_a;
  logic [5:0]  syn_h;

  logic        a_in_ready, a_valid, a_unc;
  logic [15:0] a_data;
  logic [1:0]  a_cnt;
  logic        h_in_ready, h_valid, h_unc;
  logic [15:0] h_data;
  logic [1:0]  h_cnt;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   hsel = 1'b0;
  bit   check_en = 1'b0;
  bit   exp_valid = 1'b0;
  bit   exp_ready = 1'b0;
  bit   exp_unc = 1'b0;
  logic [15:0] exp_data = '0;
  logic [1:0]  exp_cnt = '0;

  logic        m_ready, m_valid, m_unc;
  logic [15:0] m_data;
  logic [1:0]  m_cnt;

  assign m_ready = hsel ? h_in_ready : a_in_ready;
  assign m_valid = hsel ? h_valid    : a_valid;
  assign m_data  = hsel ? h_data     : a_data;
  assign m_cnt   = hsel ? h_cnt      : a_cnt;
  assign m_unc   = hsel ? h_unc      : a_unc;

  bch_correct dut (
    .clk(clk), .rst_x(rst_x), .i_enable(i_enable), .i_valid(valid_a),
    .o_in_ready(a_in_ready), .i_code(code), .i_syndrome(syn_a), .o_valid(a_valid),
    .i_out_ready(out_ready), .o_data(a_data), .o_err_cnt(a_cnt), .o_uncorrectable(a_unc)
  );

  bch_correct #(.pDataWidth(16), .pParityWidth(6), .pCodeWidth(22), .pMaxErrors(1),
                .pGenPoly(7'h6F)) dut_h (
    .clk(clk), .rst_x(rst_x), .i_enable(i_enable), .i_valid(valid_h),
    .o_in_ready(h_in_ready), .i_code(code[21:0]), .i_syndrome(syn_h), .o_valid(h_valid),
    .i_out_ready(out_ready), .o_data(h_data), .o_err_cnt(h_cnt), .o_uncorrectable(h_unc)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Remainder of the n-bit polynomial v modulo g (degree p)
  function automatic logic [63:0] modg(input logic [63:0] v, input int n, input int p,
                                       input logic [63:0] g);
    logic [63:0] r;
    r = '0;
    for (int b = n - 1; b >= 0; b--) begin
      r = (r << 1) | 64'(v[b]);
      if (r[p]) r = r ^ g;
    end
    return r;
  endfunction

  function automatic logic [63:0] colv(input int k, input int p, input logic [63:0] g);
    return modg(64'(1) << k, k + 1, p, g);
  endfunction

  function automatic logic [63:0] enc(input logic [15:0] d, input int p, input logic [63:0] g);
    logic [63:0] v;
    v = 64'(d) << p;
    return v | modg(v, 64, p, g);
  endfunction

  // Expected result and cycles from acceptance to first o_valid
  function automatic void model(input logic [63:0] cw, input int n, input int p,
                                input logic [63:0] g, input int maxe, output int lat,
                                output logic [15:0] d, output int cnt, output bit unc);
    logic [63:0] syn, fixed;
    bit found;
    syn = modg(cw, n, p, g);
    fixed = cw; cnt = 0; unc = 1'b0; found = 1'b0; lat = 2;
    if (syn != 0) begin
      for (int i = 0; i < n; i++) begin
        if (!found && colv(i, p, g) == syn) begin
          fixed = fixed ^ (64'(1) << i); cnt = 1; lat = 3 + i; found = 1'b1;
        end
        if (!found && maxe == 2) begin
          for (int k = i + 1; k < n; k++) begin
            if (!found && (colv(i, p, g) ^ colv(k, p, g)) == syn) begin
              fixed = fixed ^ (64'(1) << i) ^ (64'(1) << k); cnt = 2; lat = 3 + i; found = 1'b1;
            end
          end
        end
      end
      if (!found) begin unc = 1'b1; lat = 2 + n; end
    end
    d = 16'(fixed >> p);
  endfunction

  // Upstream syndrome calculators: registered, zero when not presented with a valid word
  always @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      syn_a <= '0;
      syn_h <= '0;
    end else begin
      syn_a <= (i_enable && valid_a) ? 11'(modg(64'(code), 27, 11, G_A)) : '0;
      syn_h <= (i_enable && valid_h) ? 6'(modg(64'(code[21:0]), 22, 6, G_H)) : '0;
    end
  end

  // Per-cycle compare against the expectation the stimulus process maintains
  always @(negedge clk) begin
    if (check_en) begin
      chk("o_valid", 64'(m_valid), 64'(exp_valid));
      chk("o_in_ready", 64'(m_ready), 64'(exp_ready));
      if (exp_valid) begin
        chk("o_data", 64'(m_data), 64'(exp_data));
        chk("o_err_cnt", 64'(m_cnt), 64'(exp_cnt));
        chk("o_uncorrectable", 64'(m_unc), 64'(exp_unc));
      end
    end
  end

  task automatic send(input logic [26:0] cw, input bit h, input int hold);
    int lat, cnt, n;
    logic [15:0] d;
    bit unc;
    hsel = h;
    if (h) model(64'(cw[21:0]), 22, 6, G_H, 1, lat, d, cnt, unc);
    else   model(64'(cw), 27, 11, G_A, 2, lat, d, cnt, unc);
    n = 0;
    while (!m_ready && n < 40) begin @(posedge clk); #1; n++; end
    if (!m_ready) chk("ready_timeout", 64'(m_ready), 64'(1));
    out_ready = (hold == 0);
    code = cw;
    if (h) valid_h = 1'b1; else valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0; valid_h = 1'b0; exp_ready = 1'b0;
    repeat (lat - 1) @(posedge clk);
    #1;
    exp_valid = 1'b1; exp_data = d; exp_cnt = 2'(cnt); exp_unc = unc;
    for (int c = 0; c < hold; c++) begin
      if (c % 3 == 1) begin
        code = 27'($urandom);
        if (h) valid_h = 1'b1; else valid_a = 1'b1;
      end
      @(posedge clk); #1;
      valid_a = 1'b0; valid_h = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_valid = 1'b0; exp_ready = 1'b1;
  endtask

  // Start a word with a late error and stop once the search is a few indices in
  task automatic start_long();
    hsel = 1'b0; out_ready = 1'b1;
    code = 27'(enc(16'hA5A5, 11, G_A)) ^ (27'(1) << 20);
    valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0; exp_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [26:0] base;
    logic [15:0] d, md;
    int lat, cnt;
    bit unc;

    rst_x = 1'b0; i_enable = 1'b1; valid_a = 1'b0; valid_h = 1'b0; out_ready = 1'b1;
    code = '0;

    // Model pins
    chk("pin_col11", colv(11, 11, G_A), 64'h1BB);
    chk("pin_col12", colv(12, 11, G_A), 64'h376);
    chk("pin_col0", colv(0, 11, G_A), 64'h1);
    base = 27'(enc(16'hA5A5, 11, G_A));
    chk("pin_enc_syn", modg(64'(base), 27, 11, G_A), 64'h0);
    model(64'(base), 27, 11, G_A, 2, lat, md, cnt, unc);
    chk("pin_clean_lat", 64'(lat), 64'd2);
    model(64'(base ^ (27'(1) << 20)), 27, 11, G_A, 2, lat, md, cnt, unc);
    chk("pin_b20_lat", 64'(lat), 64'd23);
    chk("pin_b20_data", 64'(md), 64'hA5A5);
    chk("pin_b20_cnt", 64'(cnt), 64'd1);
    model(64'(base ^ (27'(1) << 3) ^ (27'(1) << 25)), 27, 11, G_A, 2, lat, md, cnt, unc);
    chk("pin_dbl_lat", 64'(lat), 64'd6);
    chk("pin_dbl_cnt", 64'(cnt), 64'd2);
    chk("pin_dbl_data", 64'(md), 64'hA5A5);
    model(enc(16'h1234, 6, G_H) ^ 64'h100008, 22, 6, G_H, 1, lat, md, cnt, unc);
    chk("pin_h_dbl_lat", 64'(lat), 64'd24);
    chk("pin_h_dbl_unc", 64'(unc), 64'd1);

    // Reset values
    #2;
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_data", 64'(a_data), 64'd0);
    chk("rst_cnt", 64'(a_cnt), 64'd0);
    chk("rst_unc", 64'(a_unc), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_x = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 64'(a_in_ready), 64'd1);
    exp_ready = 1'b1; check_en = 1'b1;

    // Directed words
    send(base, 1'b0, 0);
    send(base ^ (27'(1) << 20), 1'b0, 0);
    send(base ^ 27'(1), 1'b0, 0);
    send(base ^ (27'(1) << 3) ^ (27'(1) << 25), 1'b0, 0);
    send(base ^ (27'(1) << 14), 1'b0, 10);
    send(27'(enc(16'h1234, 6, G_H)) ^ 27'h100008, 1'b1, 0);
    send(27'(enc(16'h1234, 6, G_H)) ^ (27'(1) << 9), 1'b1, 0);

    // Enable dropped mid-search: word discarded, idle next cycle
    start_long();
    i_enable = 1'b0;
    @(posedge clk); #1;
    i_enable = 1'b1; exp_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;

    // Reset asserted mid-search: outputs clear immediately
    start_long();
    rst_x = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(a_valid), 64'd0);
    chk("rst_mid_ready", 64'(a_in_ready), 64'd0);
    chk("rst_mid_data", 64'(a_data), 64'd0);
    chk("rst_mid_cnt", 64'(a_cnt), 64'd0);
    chk("rst_mid_unc", 64'(a_unc), 64'd0);
    exp_ready = 1'b0;
    @(posedge clk); #1;
    rst_x = 1'b1;
    @(posedge clk); #1;
    exp_ready = 1'b1;

    // Exhaustive single and double error patterns on a random word
    d = 16'($urandom);
    base = 27'(enc(d, 11, G_A));
    for (int i = 0; i < 27; i++) begin
      model(64'(base ^ (27'(1) << i)), 27, 11, G_A, 2, lat, md, cnt, unc);
      chk("exh1_model", {46'(cnt), md}, {46'd1, d});
      send(base ^ (27'(1) << i), 1'b0, 0);
    end
    for (int i = 0; i < 27; i++) begin
      for (int k = i + 1; k < 27; k++) begin
        model(64'(base ^ (27'(1) << i) ^ (27'(1) << k)), 27, 11, G_A, 2, lat, md, cnt, unc);
        chk("exh2_model", {46'(cnt), md}, {46'd2, d});
        send(base ^ (27'(1) << i) ^ (27'(1) << k), 1'b0, 0);
      end
    end

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
